// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register and a post-reset memory clear sequencer.
module dual_port_ram_be #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned READ_MODE  = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    output logic [DATA_WIDTH-1:0]   dout_a,
    output logic                    dout_valid_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   din_b,
    output logic [DATA_WIDTH-1:0]   dout_b,
    output logic                    dout_valid_b,
    output logic                    init_busy,
    output logic                    collision,
    output logic [15:0]             collision_cnt
);
    localparam int unsigned            NB      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]    DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    busy_d;
    logic                    clr_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    run;
    logic                    acc_a, acc_b;
    logic                    in_rng_a, in_rng_b;
    logic                    wr_a, wr_b;
    logic                    same_addr;
    logic                    col_d;
    logic [DATA_WIDTH-1:0]   old_a, old_b, new_a, new_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0]   q1_a, q1_b;
    logic                    v1_a, v1_b;

    // Clear sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            init_busy <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = init_busy;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST) begin
                    state_d = RUN;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            RUN:     busy_d  = 1'b0;
            default: state_d = CLEAR;
        endcase
    end

    assign run       = (state_q == RUN);
    assign acc_a     = run & en_a;
    assign acc_b     = run & en_b;
    assign in_rng_a  = {1'b0, addr_a} < DEPTH_L;
    assign in_rng_b  = {1'b0, addr_b} < DEPTH_L;
    assign wr_a      = acc_a & we_a & in_rng_a;
    assign wr_b      = acc_b & we_b & in_rng_b;
    assign same_addr = (addr_a == addr_b);
    assign col_d     = acc_a & acc_b & same_addr & (we_a | we_b);

    assign old_a = in_rng_a ? mem[addr_a] : '0;
    assign old_b = in_rng_b ? mem[addr_b] : '0;

    // Post-write word per port; on a shared address port A wins lanes both enable
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int k = 0; k < NB; k++) begin
            if (wr_b && be_b[k]) begin
                new_b[8*k +: 8] = din_b[8*k +: 8];
                if (same_addr) new_a[8*k +: 8] = din_b[8*k +: 8];
            end
            if (wr_a && be_a[k]) begin
                new_a[8*k +: 8] = din_a[8*k +: 8];
                if (same_addr) new_b[8*k +: 8] = din_a[8*k +: 8];
            end
        end
    end

    // A port that is only reading never sees the other port's write
    assign rd_a = ((READ_MODE != 0) && we_a) ? new_a : old_a;
    assign rd_b = ((READ_MODE != 0) && we_b) ? new_b : old_b;

    always_ff @(posedge clk) begin
        if (clr_we && rst) begin
            mem[ptr_q] <= '0;
        end else begin
            if (wr_a) mem[addr_a] <= new_a;
            if (wr_b) mem[addr_b] <= new_b;
        end
    end

    // First read stage; data holds when no read is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1_a <= '0;
            q1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= acc_a;
            v1_b <= acc_b;
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_a       <= '0;
                    dout_b       <= '0;
                    dout_valid_a <= 1'b0;
                    dout_valid_b <= 1'b0;
                end else begin
                    dout_valid_a <= v1_a;
                    dout_valid_b <= v1_b;
                    if (v1_a) dout_a <= q1_a;
                    if (v1_b) dout_b <= q1_b;
                end
            end
        end else begin : g_no_out_reg
            assign dout_a       = q1_a;
            assign dout_b       = q1_b;
            assign dout_valid_a = v1_a;
            assign dout_valid_b = v1_b;
        end
    endgenerate

    // Collision flag and saturating counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision     <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision <= col_d;
            if (col_d && (collision_cnt != 16'hFFFF)) collision_cnt <= collision_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: a read-first/latency-1 instance and a write-first/latency-2
// instance share stimulus and are checked against a behavioural memory model.
module tb_dual_port_ram_be;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NB    = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [NB-1:0] be_a = '0, be_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;

    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic          dv_a0, dv_b0, dv_a1, dv_b1;
    logic          busy0, busy1, col0, col1;
    logic [15:0]   cnt0, cnt1;

    logic          v [4];
    logic [DW-1:0] d [4];
    logic [DW-1:0] last_exp [4];
    exp_t          q [4][$];

    logic [DW-1:0] mem_m [DEPTH];
    int            cnt_m = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_MODE(0), .OUT_REG(0)) u_dut (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a0), .dout_valid_a(dv_a0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b0), .dout_valid_b(dv_b0),
        .init_busy(busy0), .collision(col0), .collision_cnt(cnt0)
    );

    dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_MODE(1), .OUT_REG(1)) u_dut_wf (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a1), .dout_valid_a(dv_a1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b1), .dout_valid_b(dv_b1),
        .init_busy(busy1), .collision(col1), .collision_cnt(cnt1)
    );

    assign v[0] = dv_a0;   assign d[0] = dout_a0;
    assign v[1] = dv_b0;   assign d[1] = dout_b0;
    assign v[2] = dv_a1;   assign d[2] = dout_a1;
    assign v[3] = dv_b1;   assign d[3] = dout_b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop the scoreboard whenever a read completes
    always @(negedge clk) begin : mon
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            if (v[p] !== 1'b0) begin
                if (q[p].size() == 0) begin
                    check($sformatf("spurious_valid_p%0d", p), 32'(v[p]), 32'd0);
                end else begin
                    e = q[p].pop_front();
                    check($sformatf("rdata_p%0d", p), 32'(d[p]), 32'(e.data));
                    check($sformatf("latency_p%0d", p), 32'(cyc), 32'(e.due));
                    last_exp[p] = e.data;
                end
            end
        end
    end

    task automatic idle_inputs();
        en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; din_b = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        cnt_m = 0;
        for (int p = 0; p < 4; p++) q[p].delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'({dout_a0, dout_b0}), 32'd0);
        check({tag, "_dout_wf"}, 32'({dout_a1, dout_b1}), 32'd0);
        check({tag, "_valid"}, 32'({dv_a0, dv_b0, dv_a1, dv_b1}), 32'd0);
        check({tag, "_collision"}, 32'({col0, col1}), 32'd0);
        check({tag, "_cnt"}, 32'({cnt0, cnt1}), 32'd0);
        check({tag, "_busy"}, 32'({busy0, busy1}), 32'b11);
    endtask

    // Runs the clear phase while hammering both ports with requests that must be ignored
    task automatic wait_clear();
        for (int i = 0; i < DEPTH; i++) begin
            check("init_busy_during_clear", 32'({busy0, busy1}), 32'b11);
            en_a = 1'b1; we_a = 1'b1; be_a = '1; addr_a = AW'(i);          din_a = 16'hFFFF;
            en_b = 1'b1; we_b = 1'b1; be_b = '1; addr_b = AW'(DEPTH-1-i);  din_b = 16'hA5A5;
            @(posedge clk); #1;
            check("valid_during_clear", 32'({dv_a0, dv_b0, dv_a1, dv_b1}), 32'd0);
        end
        idle_inputs();
        check("init_busy_after_clear", 32'({busy0, busy1}), 32'b00);
    endtask

    task automatic do_cycle(input logic ea, input logic wa, input logic [NB-1:0] ba,
                            input logic [AW-1:0] aa, input logic [DW-1:0] da,
                            input logic eb, input logic wb, input logic [NB-1:0] bb,
                            input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic [DW-1:0] old_a, old_b;
        logic          col;
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
        old_a = mem_m[aa];
        old_b = mem_m[ab];
        if (eb && wb)
            for (int k = 0; k < NB; k++) if (bb[k]) mem_m[ab][8*k +: 8] = db[8*k +: 8];
        if (ea && wa)
            for (int k = 0; k < NB; k++) if (ba[k]) mem_m[aa][8*k +: 8] = da[8*k +: 8];
        if (ea) begin
            q[0].push_back('{old_a, cyc + 1});
            q[2].push_back('{(wa ? mem_m[aa] : old_a), cyc + 2});
        end
        if (eb) begin
            q[1].push_back('{old_b, cyc + 1});
            q[3].push_back('{(wb ? mem_m[ab] : old_b), cyc + 2});
        end
        col = ea && eb && (aa == ab) && (wa || wb);
        if (col && cnt_m < 65535) cnt_m++;
        @(posedge clk); #1;
        check("collision", 32'(col0), 32'(col));
        check("collision_wf", 32'(col1), 32'(col));
        check("collision_cnt", 32'(cnt0), 32'(cnt_m));
        check("collision_cnt_wf", 32'(cnt1), 32'(cnt_m));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        wait_clear();

        // Every word cleared, junk writes during clear discarded
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(DEPTH-1-i), '0);

        // Byte-lane merge
        do_cycle(1, 1, 2'b11, 5'd3, 16'hBEEF, 0, 0, '0, '0, '0);
        do_cycle(1, 1, 2'b01, 5'd3, 16'h1234, 0, 0, '0, '0, '0);
        do_cycle(1, 0, 2'b00, 5'd3, 16'h0000, 0, 0, '0, '0, '0);

        // Same-port read during write
        do_cycle(1, 1, 2'b11, 5'd5, 16'h1111, 0, 0, '0, '0, '0);
        do_cycle(1, 1, 2'b11, 5'd5, 16'h2222, 0, 0, '0, '0, '0);
        do_cycle(0, 0, '0, '0, '0, 1, 0, '0, 5'd5, '0);

        // Both ports write the same word
        do_cycle(1, 1, 2'b11, 5'd7, 16'hAAAA, 1, 1, 2'b11, 5'd7, 16'h5555);
        do_cycle(1, 0, '0, 5'd7, '0, 0, 0, '0, '0, '0);
        do_cycle(1, 1, 2'b10, 5'd7, 16'hAAAA, 1, 1, 2'b11, 5'd7, 16'h5555);
        do_cycle(1, 0, '0, 5'd7, '0, 0, 0, '0, '0, '0);

        // One port writes while the other reads the same word; then both read
        do_cycle(1, 1, 2'b11, 5'd9, 16'h0F0F, 0, 0, '0, '0, '0);
        do_cycle(1, 1, 2'b11, 5'd9, 16'hF0F0, 1, 0, '0, 5'd9, '0);
        do_cycle(1, 0, '0, 5'd9, '0, 1, 0, '0, 5'd9, '0);

        // Random traffic on a narrow address window to provoke conflicts
        for (int i = 0; i < 200; i++)
            do_cycle(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), 16'($urandom),
                     1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), 16'($urandom));

        drain(4);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("pending_p%0d", p), 32'(q[p].size()), 32'd0);
            check($sformatf("dout_hold_p%0d", p), 32'(d[p]), 32'(last_exp[p]));
        end

        // Reset while running: outputs clear at once, clear sequence restarts
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("busy_mid_clear", 32'({busy0, busy1}), 32'b11);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_clear");
        @(posedge clk); #1;
        rst = 1'b1;
        wait_clear();

        do_cycle(1, 0, '0, 5'd3, '0, 1, 0, '0, 5'd7, '0);
        do_cycle(1, 0, '0, 5'd9, '0, 1, 0, '0, 5'd5, '0);
        drain(3);
        for (int p = 0; p < 4; p++)
            check($sformatf("final_pending_p%0d", p), 32'(q[p].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Parametrised true dual-port RAM with per-byte write enables, selectable read-during-write mode and optional output register. Replaces the single-cycle-reset 16x8 dual-port RAM as the general storage primitive. Memory is cleared by a post-reset sequencer, not in one cycle. Cross-port address collisions have fixed resolution rules and are flagged and counted.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDR_WIDTH, 5, address width
DEPTH, 32, number of words; must be <= 2**ADDR_WIDTH
READ_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1 cycle, 1 = read latency 2 cycles (extra output register)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
en_a  input  1  port A access enable
we_a  input  1  port A write (valid only with en_a)
be_a  input  DATA_WIDTH/8  port A byte-lane write enables
addr_a  input  ADDR_WIDTH  port A address
din_a  input  DATA_WIDTH  port A write data
dout_a  output  DATA_WIDTH  port A read data
dout_valid_a  output  1  port A read data valid strobe
en_b, we_b, be_b, addr_b, din_b, dout_b, dout_valid_b: same as port A, for port B
init_busy  output  1  memory clear in progress; all port requests ignored
collision  output  1  one-cycle pulse: cross-port same-address conflict
collision_cnt  output  16  saturating count of collisions

Behaviour:
- Reset: rst=0 asynchronously forces dout_a/b=0, dout_valid_a/b=0, collision=0, collision_cnt=0, clear pointer=0, init_busy=1. Memory is not touched asynchronously.
- FSM states: CLEAR and RUN. Reset enters CLEAR.
- CLEAR: one word per cycle, mem[ptr]<=0, ptr increments. After the write to DEPTH-1, move to RUN. init_busy is 1 for exactly DEPTH cycles after rst rises, then falls.
- In CLEAR, all en/we inputs are ignored and dout_valid stays 0.
- rst asserted mid-CLEAR or mid-RUN restarts CLEAR from address 0.
- Read: any en_x=1 cycle in RUN is a read of addr_x, including write cycles.
  - OUT_REG=0: dout_x and dout_valid_x update on the next edge.
  - OUT_REG=1: update one edge later; the valid pipeline matches the data pipeline.
  - dout_valid_x is a 1-cycle pulse per accepted access.
  - dout_x holds its last value when no read completes.
- Write: en_x & we_x writes din_x byte lane k only where be_x[k]=1. Other lanes keep their old value. be_x=0 is a pure read.
- Same-port read-during-write:
  - READ_MODE=0: dout returns the pre-write word.
  - READ_MODE=1: dout returns the post-write merged word.
- addr_x >= DEPTH: writes dropped, reads return 0, dout_valid still pulses.
- Collision: en_a & en_b & addr_a==addr_b & (we_a|we_b) in RUN.
  - Both writing: lanes enabled on both ports take port A data. Lanes enabled on one port only take that port's data.
  - One writing, one reading: the reading port always gets the pre-write word, regardless of READ_MODE.
  - Both reading at the same address is not a collision.
  - collision pulses 1 cycle after the conflict cycle. collision_cnt increments with it and saturates at 0xFFFF.
- Out-of-range collisions (addr >= DEPTH) are still flagged.

Test Plan:
- Reset release, DEPTH=32: init_busy=1 for 32 cycles then 0. Read all addresses -> all 0x0000. An en_a pulse during CLEAR -> no dout_valid_a.
- A writes 0xBEEF to addr 3 with be=2'b11, then be=2'b01 din=0x1234. Read A addr 3 -> 0xBE34, valid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
- READ_MODE=0: mem[5]=0x1111, A writes 0x2222 to 5 with read -> dout_a=0x1111. READ_MODE=1, same stimulus -> dout_a=0x2222.
- Same cycle addr 7: A writes 0xAAAA be=2'b11, B writes 0x5555 be=2'b11 -> mem[7]=0xAAAA, collision pulse, cnt=1. Repeat with be_a=2'b10, be_b=2'b11 -> mem[7]=0xAA55, cnt=2.
- mem[9]=0x0F0F, A writes 0xF0F0 to 9 while B reads 9 -> dout_b=0x0F0F, mem[9]=0xF0F0, collision=1. Both read addr 9 -> no collision.
- Assert rst mid-CLEAR at ptr=10: outputs zero immediately. After release, init_busy lasts a full 32 cycles. collision_cnt reads 0.
